// File: rtl/rf_writeback_arbiter_if.sv
// Producer-side handshakes (ALU, crypto unit) and register-file write port
// bundled for rf_writeback_arbiter; slave = arbiter side, master = producers/RF.
interface rf_writeback_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              cu_valid;
  logic              cu_ready;
  logic [ADDR_W-1:0] cu_reg;
  logic [DATA_W-1:0] cu_data;
  logic              write_enable;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;

  modport slave (
    input  alu_valid, alu_reg, alu_data, cu_valid, cu_reg, cu_data,
    output alu_ready, cu_ready, write_enable, write_reg, write_data
  );

  modport master (
    output alu_valid, alu_reg, alu_data, cu_valid, cu_reg, cu_data,
    input  alu_ready, cu_ready, write_enable, write_reg, write_data
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: ALU has priority, crypto-unit results queue in a FIFO
// with a starvation override. Optional pending-write bitmap via RF_WB_PEND_MASK_EN.
module rf_writeback_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_writeback_arbiter_if.slave bus
`ifdef RF_WB_PEND_MASK_EN
  ,
  output logic [31:0]           pend_mask
`endif
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {SEL_IDLE, SEL_ALU, SEL_FIFO} sel_e;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic   fifo_full, fifo_nonempty, force_head, push, pop;
  sel_e   sel;
  entry_t winner;

  assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign force_head    = fifo_nonempty && (starve_q == STV_W'(STARVE_LIMIT));

  // Readiness depends on registered state only, so a pop never frees a slot the same cycle.
  assign bus.cu_ready  = !fifo_full;
  assign bus.alu_ready = !force_head;
  assign push          = bus.cu_valid && !fifo_full;
  assign pop           = (sel == SEL_FIFO);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel = SEL_IDLE;
    if (force_head)         sel = SEL_FIFO;
    else if (bus.alu_valid) sel = SEL_ALU;
    else if (fifo_nonempty) sel = SEL_FIFO;
  end

  always_comb begin
    winner = mem_q[rd_ptr_q];
    if (sel == SEL_ALU) winner = '{rd: bus.alu_reg, data: bus.alu_data};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    starve_d = starve_q;
    if (!fifo_nonempty || pop)                   starve_d = '0;
    else if (starve_q != STV_W'(STARVE_LIMIT))   starve_d = starve_q + STV_W'(1);

    // Idle cycles drop the strobe but keep the last index/data on the port.
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (sel != SEL_IDLE) begin
      we_d    = (winner.rd != '0);
      wreg_d  = winner.rd;
      wdata_d = winner.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; only slots inside the occupancy window are read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: bus.cu_reg, data: bus.cu_data};
  end

  assign bus.write_enable = we_q;
  assign bus.write_reg    = wreg_q;
  assign bus.write_data   = wdata_q;

`ifdef RF_WB_PEND_MASK_EN
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < count_q) pend_mask[mem_q[rd_ptr_q + PTR_W'(i)].rd] = 1'b1;
    end
    if (we_q) pend_mask[wreg_q] = 1'b1;
    pend_mask[0] = 1'b0;
  end
`endif
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the arbitration rules.
module tb_rf_writeback_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
`ifdef RF_WB_PEND_MASK_EN
  logic [31:0] pend_mask;
`endif

  rf_writeback_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RF_WB_PEND_MASK_EN
    ,
    .pend_mask (pend_mask)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  cmp_en  = 1'b0;
  wr_t dut_log [$];

  // Reference model: queue of pending CU results, head wait time, expected write port.
  wr_t               fifo_m [$];
  int                wait_m;
  logic              exp_we;
  logic [ADDR_W-1:0] exp_reg;
  logic [DATA_W-1:0] exp_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    bit  had, full, popped, win;
    wr_t w;
    if (rst) begin
      fifo_m.delete();
      wait_m   = 0;
      exp_we   = 1'b0;
      exp_reg  = '0;
      exp_data = '0;
    end else begin
      had    = fifo_m.size() > 0;
      full   = fifo_m.size() == DEPTH;
      popped = 1'b0;
      win    = 1'b0;
      w.rd   = '0;
      w.data = '0;
      if (had && wait_m == LIMIT) begin
        w = fifo_m.pop_front(); popped = 1'b1; win = 1'b1;
      end else if (bus.alu_valid) begin
        w.rd = bus.alu_reg; w.data = bus.alu_data; win = 1'b1;
      end else if (had) begin
        w = fifo_m.pop_front(); popped = 1'b1; win = 1'b1;
      end
      if (bus.cu_valid && !full) begin
        wr_t c;
        c.rd = bus.cu_reg; c.data = bus.cu_data;
        fifo_m.push_back(c);
      end
      if (!had || popped) wait_m = 0;
      else if (wait_m < LIMIT) wait_m = wait_m + 1;
      if (win) begin
        exp_we = (w.rd != 0); exp_reg = w.rd; exp_data = w.data;
      end else begin
        exp_we = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    wr_t         e;
    logic [31:0] m;
    if (cmp_en) begin
      check("alu_ready", bus.alu_ready, !(fifo_m.size() > 0 && wait_m == LIMIT));
      check("cu_ready", bus.cu_ready, fifo_m.size() < DEPTH);
      check("write_enable", bus.write_enable, exp_we);
      check("write_reg", bus.write_reg, exp_reg);
      check("write_data", bus.write_data, exp_data);
`ifdef RF_WB_PEND_MASK_EN
      m = '0;
      foreach (fifo_m[i]) m[fifo_m[i].rd] = 1'b1;
      if (exp_we) m[exp_reg] = 1'b1;
      m[0] = 1'b0;
      check("pend_mask", pend_mask, m);
`endif
      if (bus.write_enable) begin
        e.rd = bus.write_reg; e.data = bus.write_data;
        dut_log.push_back(e);
      end
    end
  end

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.cu_valid  = 1'b0; bus.cu_reg  = '0; bus.cu_data  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (fifo_m.size() > 0 && k < 50) begin
      step();
      k++;
    end
    check("drain_timeout", fifo_m.size(), 0);
    step();
  endtask

  initial begin
    int k;
    int pct;
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    @(negedge clk);
    check("rst_we", bus.write_enable, 1'b0);
    check("rst_reg", bus.write_reg, 0);
    check("rst_data", bus.write_data, 0);
    check("rst_cu_ready", bus.cu_ready, 1'b1);
    cmp_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // T1: ALU write appears one cycle after acceptance.
    bus.alu_valid = 1'b1; bus.alu_reg = 5; bus.alu_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_alu_ready", bus.alu_ready, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    check("t1_we", bus.write_enable, 1'b1);
    check("t1_reg", bus.write_reg, 5);
    check("t1_data", bus.write_data, 32'hDEADBEEF);
    step();

    // T2: CU result goes through the FIFO, written two cycles later.
    bus.cu_valid = 1'b1; bus.cu_reg = 7; bus.cu_data = 32'h1234;
    @(negedge clk);
    check("t2_cu_ready0", bus.cu_ready, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    check("t2_no_cut_through", bus.write_enable, 1'b0);
    check("t2_cu_ready1", bus.cu_ready, 1'b1);
    step();
    @(negedge clk);
    check("t2_we", bus.write_enable, 1'b1);
    check("t2_reg", bus.write_reg, 7);
    check("t2_data", bus.write_data, 32'h1234);
    repeat (2) step();

    // T3: fill FIFO under continuous ALU pressure, starvation override fires.
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 3; bus.alu_data = 32'h300 + i;
      bus.cu_valid  = 1'b1; bus.cu_reg  = ADDR_W'(10 + i); bus.cu_data = 32'hC0 + i;
      step();
    end
    bus.cu_valid = 1'b0;
    @(negedge clk);
    check("t3_full", bus.cu_ready, 1'b0);
    k = 4;
    while (bus.alu_ready && k < 20) begin
      step();
      k++;
      @(negedge clk);
    end
    check("t3_force_cycle", k, 9);
    step();
    @(negedge clk);
    check("t3_head_we", bus.write_enable, 1'b1);
    check("t3_head_reg", bus.write_reg, 10);
    check("t3_head_data", bus.write_data, 32'hC0);
    check("t3_restart", bus.alu_ready, 1'b1);
    step();
    idle_inputs();
    drain();

    // T4: r0 is accepted but never strobes the RF.
    bus.alu_valid = 1'b1; bus.alu_reg = 0; bus.alu_data = 32'hFFFFFFFF;
    @(negedge clk);
    check("t4_alu_ready", bus.alu_ready, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    check("t4_we", bus.write_enable, 1'b0);
`ifdef RF_WB_PEND_MASK_EN
    check("t4_pend0", pend_mask[0], 1'b0);
`endif
    step();

    // T5: back-to-back CU traffic across pointer wrap.
    dut_log.delete();
    for (int i = 1; i <= 10; i++) begin
      bus.cu_valid = 1'b1; bus.cu_reg = ADDR_W'(i); bus.cu_data = 32'hA5000000 | i;
      step();
    end
    idle_inputs();
    drain();
    step();
    check("t5_len", dut_log.size(), 10);
    for (int i = 0; i < 10 && i < dut_log.size(); i++) begin
      check("t5_reg", dut_log[i].rd, i + 1);
      check("t5_data", dut_log[i].data, 32'hA5000000 | (i + 1));
    end

    // T6: reset with queued CU entries discards them.
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 2; bus.alu_data = 32'h22;
      bus.cu_valid  = 1'b1; bus.cu_reg  = ADDR_W'(20 + i); bus.cu_data = 32'hE0 + i;
      step();
    end
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dut_log.delete();
    @(negedge clk);
    check("t6_we", bus.write_enable, 1'b0);
    check("t6_cu_ready", bus.cu_ready, 1'b1);
    repeat (20) step();
    check("t6_no_writes", dut_log.size(), 0);

    // Randomized traffic with varying ALU pressure and one mid-run reset.
    for (int blk = 0; blk < 15; blk++) begin
      pct = (blk % 3 == 0) ? 20 : (blk % 3 == 1) ? 60 : 100;
      for (int c = 0; c < 200; c++) begin
        bus.alu_valid = ($urandom_range(0, 99) < pct);
        bus.alu_reg   = ADDR_W'($urandom_range(0, 31));
        bus.alu_data  = $urandom;
        bus.cu_valid  = ($urandom_range(0, 99) < 50);
        bus.cu_reg    = ADDR_W'($urandom_range(0, 31));
        bus.cu_data   = $urandom;
        rst           = (blk == 7 && c == 100);
        step();
      end
    end
    rst = 1'b0;
    idle_inputs();
    drain();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
